// File: rtl/skip_adder8_checker.sv
// ---------------------------------------------------------------------------
// skip_adder8_checker
//
// Response checker for the 8-bit carry-skip adder datapath. Accepts adder
// stimulus/response vectors over a valid/ready handshake, recomputes the
// golden 9-bit sum, counts mismatches, captures the first failing vector and
// folds every DUT result into a 16-bit MISR signature.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   start, num_vec        begin a session of num_vec vectors (IDLE/DONE only)
//   in_valid, in_ready    vector handshake
//   in_a, in_b, in_ci     operands applied to the adder
//   in_s, in_co           adder response
//   busy, done, pass      session status (pass = done with zero errors)
//   vec_cnt, err_cnt      vectors compared, mismatches (saturating)
//   ff_valid/idx/vec      first-fail capture: index and {a,b,ci,s,co}
//   signature             MISR over {co,s} of every compared vector
// ---------------------------------------------------------------------------
module skip_adder8_checker #(
  parameter int NV_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [NV_W-1:0] num_vec,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      in_a,
  input  logic [7:0]      in_b,
  input  logic            in_ci,
  input  logic [7:0]      in_s,
  input  logic            in_co,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [NV_W-1:0] vec_cnt,
  output logic [NV_W-1:0] err_cnt,
  output logic            ff_valid,
  output logic [NV_W-1:0] ff_idx,
  output logic [25:0]     ff_vec,
  output logic [15:0]     signature
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state;
  logic [NV_W-1:0] nv_q;
  logic [NV_W-1:0] acc_cnt;

  logic            accept;
  logic            last_accept;
  logic            session_clr;

  // Stage 1: registered copy of the accepted vector {a, b, ci, s, co}.
  logic            s1_valid;
  logic [25:0]     s1_vec;

  logic [7:0]      s1_a;
  logic [7:0]      s1_b;
  logic            s1_ci;
  logic [8:0]      s1_res;
  logic [8:0]      exp_sum;
  logic            mismatch;

  function automatic logic [15:0] misr_next(input logic [15:0] sig,
                                            input logic [8:0]  res);
    logic [15:0] shifted;
    shifted = {sig[14:0], 1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000);
    return shifted ^ {7'b0, res};
  endfunction

  assign accept      = in_valid && in_ready;
  assign last_accept = accept && (acc_cnt == nv_q - NV_W'(1));
  assign session_clr = start && ((state == IDLE) || (state == DONE));

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);
  assign pass = done && (err_cnt == '0);

  // Control FSM; in_ready is registered so it rises the cycle after start
  // and falls the cycle after the final accept.
  // NOTE: state is updated with non-blocking assignments so every register in
  // the design samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      nv_q     <= '0;
      acc_cnt  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            nv_q    <= num_vec;
            acc_cnt <= '0;
            if (num_vec == '0) begin
              state    <= DONE;
              in_ready <= 1'b0;
            end else begin
              state    <= RUN;
              in_ready <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            acc_cnt <= acc_cnt + NV_W'(1);
            if (last_accept) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
            end
          end
        end
        // Stage 1 is the only in-flight slot and it retires on this edge,
        // so the pipeline is empty by the time DONE is visible.
        DRAIN:   state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stage 1 capture.
  // NOTE: the payload register is reset as well so a reset always discards
  // in-flight data and ff_vec can never pick up stale bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_vec   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) s1_vec <= {in_a, in_b, in_ci, in_s, in_co};
    end
  end

  assign s1_a     = s1_vec[25:18];
  assign s1_b     = s1_vec[17:10];
  assign s1_ci    = s1_vec[9];
  assign s1_res   = {s1_vec[0], s1_vec[8:1]};
  assign exp_sum  = 9'(s1_a) + 9'(s1_b) + 9'(s1_ci);
  assign mismatch = (s1_res != exp_sum);

  // Stage 2: compare, count, capture first fail, compact into the MISR.
  // A session clear can only happen in IDLE/DONE, where stage 1 is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_cnt   <= '0;
      err_cnt   <= '0;
      ff_valid  <= 1'b0;
      ff_idx    <= '0;
      ff_vec    <= '0;
      signature <= 16'hFFFF;
    end else if (session_clr) begin
      vec_cnt   <= '0;
      err_cnt   <= '0;
      ff_valid  <= 1'b0;
      ff_idx    <= '0;
      ff_vec    <= '0;
      signature <= 16'hFFFF;
    end else if (s1_valid) begin
      vec_cnt   <= vec_cnt + NV_W'(1);
      signature <= misr_next(signature, s1_res);
      if (mismatch) begin
        if (err_cnt != '1) err_cnt <= err_cnt + NV_W'(1);
        if (!ff_valid) begin
          ff_valid <= 1'b1;
          ff_idx   <= vec_cnt;
          ff_vec   <= s1_vec;
        end
      end
    end
  end

endmodule

// File: tb/tb_skip_adder8_checker.sv
// ---------------------------------------------------------------------------
// tb_skip_adder8_checker
//
// Self-checking bench for skip_adder8_checker. A behavioural model tracks the
// session from the handshake rules and arithmetic; a compare process checks
// every DUT output against it on each falling edge, and directed scenarios
// add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_skip_adder8_checker;

  localparam int NV_W = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [NV_W-1:0] num_vec = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [7:0]      in_a = '0;
  logic [7:0]      in_b = '0;
  logic            in_ci = 1'b0;
  logic [7:0]      in_s = '0;
  logic            in_co = 1'b0;
  logic            busy, done, pass;
  logic [NV_W-1:0] vec_cnt, err_cnt, ff_idx;
  logic            ff_valid;
  logic [25:0]     ff_vec;
  logic [15:0]     signature;

  skip_adder8_checker #(.NV_W(NV_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_vec(num_vec),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_ci(in_ci), .in_s(in_s), .in_co(in_co),
    .busy(busy), .done(done), .pass(pass),
    .vec_cnt(vec_cnt), .err_cnt(err_cnt),
    .ff_valid(ff_valid), .ff_idx(ff_idx), .ff_vec(ff_vec),
    .signature(signature)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit cmp_en   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {M_IDLE, M_RUN, M_DRAIN, M_DONE} mstate_t;
  mstate_t m_st = M_IDLE;
  bit      m_ready = 0;
  int      m_nv = 0, m_acc = 0, m_vec = 0, m_err = 0, m_ffidx = 0;
  bit      m_ffv = 0;
  logic [25:0] m_ffvec = '0;
  logic [15:0] m_sig = 16'hFFFF;
  bit          m_pend_v = 0;
  logic [25:0] m_pend = '0;

  function automatic logic [15:0] misr_step(input logic [15:0] sig,
                                            input logic [8:0] r);
    return ({sig[14:0], 1'b0} ^ (sig[15] ? 16'h1021 : 16'h0)) ^ {7'b0, r};
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_st = M_IDLE; m_ready = 0; m_nv = 0; m_acc = 0; m_vec = 0;
        m_err = 0; m_ffidx = 0; m_ffv = 0; m_ffvec = '0; m_sig = 16'hFFFF;
        m_pend_v = 0;
      end else begin
        // retire the vector accepted on the previous edge
        if (m_pend_v) begin
          int sum, got;
          sum = int'(m_pend[25:18]) + int'(m_pend[17:10]) + int'(m_pend[9]);
          got = int'({m_pend[0], m_pend[8:1]});
          if (got != sum) begin
            if (m_err < 65535) m_err++;
            if (!m_ffv) begin m_ffv = 1; m_ffidx = m_vec; m_ffvec = m_pend; end
          end
          m_vec++;
          m_sig = misr_step(m_sig, {m_pend[0], m_pend[8:1]});
        end
        m_pend_v = 0;
        case (m_st)
          M_IDLE, M_DONE: if (start) begin
            m_nv = int'(num_vec); m_acc = 0; m_vec = 0; m_err = 0;
            m_ffv = 0; m_ffidx = 0; m_ffvec = '0; m_sig = 16'hFFFF;
            m_st = (m_nv == 0) ? M_DONE : M_RUN;
            m_ready = (m_nv != 0);
          end
          M_RUN: if (in_valid && m_ready) begin
            m_pend_v = 1; m_pend = {in_a, in_b, in_ci, in_s, in_co};
            m_acc++;
            if (m_acc == m_nv) begin m_st = M_DRAIN; m_ready = 0; end
          end
          M_DRAIN: m_st = M_DONE;
          default: ;
        endcase
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("in_ready", 32'(in_ready), 32'(m_ready));
        check("busy", 32'(busy), 32'(m_st == M_RUN || m_st == M_DRAIN));
        check("done", 32'(done), 32'(m_st == M_DONE));
        check("pass", 32'(pass), 32'(m_st == M_DONE && m_err == 0));
        check("vec_cnt", 32'(vec_cnt), 32'(m_vec));
        check("err_cnt", 32'(err_cnt), 32'(m_err));
        check("ff_valid", 32'(ff_valid), 32'(m_ffv));
        check("ff_idx", 32'(ff_idx), 32'(m_ffidx));
        check("ff_vec", 32'(ff_vec), 32'(m_ffvec));
        check("signature", 32'(signature), 32'(m_sig));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // All helpers start and end at posedge+#1.
  task automatic do_start(input int nv);
    start = 1'b1; num_vec = NV_W'(nv);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic ci,
                      input logic [7:0] s, input logic co, input bit rnd);
    int  gaps;
    bit  ok;
    gaps = rnd ? int'($urandom_range(0, 2)) : 0;
    in_valid = 1'b0;
    repeat (gaps) begin @(posedge clk); #1; end
    in_a = a; in_b = b; in_ci = ci; in_s = s; in_co = co; in_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1;
      if (ok) begin in_valid = 1'b0; return; end
    end
    in_valid = 1'b0;
    check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int budget);
    for (int t = 0; t < budget; t++) begin
      if (done) return;
      @(posedge clk); #1;
    end
    check("done_timeout", 32'(done), 32'd1);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int start_cyc;
    logic [7:0] s_v;

    repeat (3) @(posedge clk);
    #1;
    // reset values
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_vec_cnt", 32'(vec_cnt), 32'd0);
    check("rst_ff_valid", 32'(ff_valid), 32'd0);
    check("rst_signature", 32'(signature), 32'hFFFF);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    @(posedge clk); #1;

    // 1: two correct vectors back to back
    start_cyc = cyc;
    do_start(2);
    check("t1_in_ready", 32'(in_ready), 32'd1);
    send(8'd5, 8'd10, 1'b1, 8'd16, 1'b0, 1'b0);
    send(8'd10, 8'd33, 1'b0, 8'd43, 1'b0, 1'b0);
    wait_done(10);
    check("t1_latency", 32'(cyc - start_cyc), 32'd4);
    check("t1_pass", 32'(pass), 32'd1);
    check("t1_vec_cnt", 32'(vec_cnt), 32'd2);
    check("t1_err_cnt", 32'(err_cnt), 32'd0);
    check("t1_ff_valid", 32'(ff_valid), 32'd0);
    check("t1_signature", 32'(signature), 32'hCF94);

    // 2: one mismatch in the middle
    do_start(3);
    send(8'd255, 8'd1, 1'b0, 8'd0, 1'b1, 1'b0);
    send(8'd255, 8'd1, 1'b0, 8'd1, 1'b0, 1'b0);
    send(8'd0, 8'd0, 1'b1, 8'd1, 1'b0, 1'b0);
    wait_done(10);
    check("t2_err_cnt", 32'(err_cnt), 32'd1);
    check("t2_ff_idx", 32'(ff_idx), 32'd1);
    check("t2_ff_vec", 32'(ff_vec), 32'({8'd255, 8'd1, 1'b0, 8'd1, 1'b0}));
    check("t2_pass", 32'(pass), 32'd0);

    // 3: empty session
    do_start(0);
    check("t3_done", 32'(done), 32'd1);
    check("t3_pass", 32'(pass), 32'd1);
    check("t3_signature", 32'(signature), 32'hFFFF);
    check("t3_in_ready", 32'(in_ready), 32'd0);

    // 4a: 4th vector offered after num_vec=3 accepted
    do_start(3);
    for (int i = 0; i < 3; i++) send(8'(i), 8'd0, 1'b0, 8'(i), 1'b0, 1'b1);
    in_a = 8'd99; in_b = 8'd0; in_ci = 1'b0; in_s = 8'd99; in_co = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t4_ready_low", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("t4_done", 32'(done), 32'd1);
    check("t4_vec_cnt", 32'(vec_cnt), 32'd3);

    // 4b: exhaustive a with b=0, ci=0, random gaps and random corruption
    do_start(256);
    for (int i = 0; i < 256; i++) begin
      s_v = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'(i);
      send(8'(i), 8'd0, 1'b0, s_v, 1'($urandom_range(0, 15) == 0), 1'b1);
    end
    wait_done(10);
    check("t4b_vec_cnt", 32'(vec_cnt), 32'd256);
    check("t4b_signature", 32'(signature), 32'(m_sig));

    // 5: reset in the middle of a run
    do_start(10);
    for (int i = 0; i < 5; i++) send(8'(i), 8'd1, 1'b0, 8'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t5_in_ready", 32'(in_ready), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_vec_cnt", 32'(vec_cnt), 32'd0);
    check("t5_err_cnt", 32'(err_cnt), 32'd0);
    check("t5_ff_valid", 32'(ff_valid), 32'd0);
    check("t5_ff_idx", 32'(ff_idx), 32'd0);
    check("t5_ff_vec", 32'(ff_vec), 32'd0);
    check("t5_signature", 32'(signature), 32'hFFFF);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_start(1);
    send(8'd100, 8'd200, 1'b1, 8'd45, 1'b1, 1'b0);
    wait_done(10);
    check("t5_restart_pass", 32'(pass), 32'd1);
    check("t5_restart_vec", 32'(vec_cnt), 32'd1);

    // 6: every vector wrong, maximum session length
    cmp_en = 1'b0;
    do_start(16'hFFFF);
    in_a = 8'd0; in_b = 8'd0; in_ci = 1'b0; in_s = 8'd1; in_co = 1'b0;
    in_valid = 1'b1;
    wait_done(70000);
    in_valid = 1'b0;
    check("t6_err_cnt", 32'(err_cnt), 32'hFFFF);
    check("t6_vec_cnt", 32'(vec_cnt), 32'hFFFF);
    check("t6_ff_idx", 32'(ff_idx), 32'd0);
    check("t6_ff_vec", 32'(ff_vec), 32'h2);
    check("t6_pass", 32'(pass), 32'd0);
    @(posedge clk); #1;
    cmp_en = 1'b1;
    // extra session starts from clean counters
    do_start(1);
    send(8'd7, 8'd8, 1'b0, 8'd15, 1'b0, 1'b0);
    wait_done(10);
    check("t6_extra_err", 32'(err_cnt), 32'd0);
    check("t6_extra_pass", 32'(pass), 32'd1);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
